// File: rtl/mcu_scheduler_pkg.sv
// Shared types for the MCU block-order scheduler: FSM states, scan config bundle, default sizes.
package mcu_scheduler_pkg;

  localparam int unsigned CH_DEF      = 3;
  localparam int unsigned MAX_BLK_DEF = 10;
  localparam int unsigned MCU_W_DEF   = 16;
  localparam int unsigned CW_DEF      = $clog2(CH_DEF + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StDc,
    StAc,
    StRstWait,
    StDone
  } sched_state_e;

  // Scan configuration at the default component count.
  typedef struct packed {
    logic [CW_DEF-1:0]        num_ch;
    logic [CH_DEF-1:0][3:0]   blk_per_ch;
    logic [MCU_W_DEF-1:0]     total_mcus;
    logic [MCU_W_DEF-1:0]     rst_interval;
  } mcu_cfg_t;

endpackage

// File: rtl/mcu_position_counter.sv
// Tracks the (block, component) position inside an MCU plus the MCU and restart-interval counters.
module mcu_position_counter
  import mcu_scheduler_pkg::*;
#(
  parameter int unsigned CH    = CH_DEF,
  parameter int unsigned MCU_W = MCU_W_DEF,
  localparam int unsigned CW   = $clog2(CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  input  logic [CW-1:0]        num_ch,
  input  logic [CH-1:0][3:0]   blk_per_ch,
  input  logic [MCU_W-1:0]     total_mcus,
  input  logic [MCU_W-1:0]     rst_interval,
  output logic [CW-1:0]        ch_idx,
  output logic [MCU_W-1:0]     mcu_cnt,
  output logic                 mcu_end,
  output logic                 scan_end,
  output logic                 interval_end
);

  logic [1:0]       blk_idx_q, blk_idx_d;
  logic [CW-1:0]    ch_idx_q, ch_idx_d;
  logic [MCU_W-1:0] mcu_cnt_q, mcu_cnt_d;
  logic [MCU_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [3:0]       cur_blks;
  logic             last_blk, last_ch;
  logic [MCU_W-1:0] mcu_nxt, rst_nxt;

  always_comb begin
    cur_blks = 4'd0;
    for (int i = 0; i < CH; i++) begin
      if (ch_idx_q == CW'(i)) cur_blks = blk_per_ch[i];
    end
  end

  assign last_blk     = ({2'b00, blk_idx_q} + 4'd1) >= cur_blks;
  assign last_ch      = ch_idx_q == (num_ch - CW'(1));
  assign mcu_nxt      = mcu_cnt_q + MCU_W'(1);
  assign rst_nxt      = rst_cnt_q + MCU_W'(1);
  assign mcu_end      = adv & last_blk & last_ch;
  assign scan_end     = mcu_end & (mcu_nxt == total_mcus);
  // The final MCU of the scan never waits for a marker.
  assign interval_end = mcu_end & ~scan_end & (rst_interval != '0) & (rst_nxt == rst_interval);

  always_comb begin
    blk_idx_d = blk_idx_q;
    ch_idx_d  = ch_idx_q;
    mcu_cnt_d = mcu_cnt_q;
    rst_cnt_d = rst_cnt_q;
    if (clr) begin
      blk_idx_d = '0;
      ch_idx_d  = '0;
      mcu_cnt_d = '0;
      rst_cnt_d = '0;
    end else if (adv) begin
      if (!last_blk) begin
        blk_idx_d = blk_idx_q + 2'd1;
      end else begin
        blk_idx_d = '0;
        ch_idx_d  = last_ch ? '0 : ch_idx_q + CW'(1);
      end
      if (mcu_end) begin
        mcu_cnt_d = mcu_nxt;
        rst_cnt_d = interval_end ? '0 : rst_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_idx_q <= '0;
      ch_idx_q  <= '0;
      mcu_cnt_q <= '0;
      rst_cnt_q <= '0;
    end else begin
      blk_idx_q <= blk_idx_d;
      ch_idx_q  <= ch_idx_d;
      mcu_cnt_q <= mcu_cnt_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  assign ch_idx  = ch_idx_q;
  assign mcu_cnt = mcu_cnt_q;

endmodule

// File: rtl/mcu_scheduler.sv
// Runtime-configured MCU block order and DC/AC phase controller with restart-marker resync.
module mcu_scheduler
  import mcu_scheduler_pkg::*;
#(
  parameter int unsigned CH      = CH_DEF,
  parameter int unsigned MAX_BLK = MAX_BLK_DEF,
  parameter int unsigned MCU_W   = MCU_W_DEF,
  localparam int unsigned CW     = $clog2(CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CW-1:0]        cfg_num_ch,
  input  logic [CH-1:0][3:0]   cfg_blk_per_ch,
  input  logic [MCU_W-1:0]     cfg_total_mcus,
  input  logic [MCU_W-1:0]     cfg_rst_interval,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ibuff_valid,
  input  logic                 huff_valid,
  input  logic                 blk_done,
  input  logic                 marker_seen,
  input  logic [2:0]           marker_num,
  output logic [CW-1:0]        ch,
  output logic [CW-1:0]        ch_out,
  output logic                 freq,
  output logic                 dc_pred_clr,
  output logic                 rst_wait,
  output logic                 busy,
  output logic                 scan_done,
  output logic [MCU_W-1:0]     mcu_cnt,
  output logic                 err
);

  sched_state_e     state_q, state_d;
  logic [CW-1:0]    num_ch_q, num_ch_d;
  logic [CH-1:0][3:0] blk_per_ch_q, blk_per_ch_d;
  logic [MCU_W-1:0] total_q, total_d;
  logic [MCU_W-1:0] interval_q, interval_d;
  logic [2:0]       exp_rst_q, exp_rst_d;
  logic             err_q, err_d;
  logic             dc_clr_q, dc_clr_d;
  logic [CW-1:0]    ch_out_q;

  logic             cfg_ok, blk_ok;
  int unsigned      blk_sum;
  logic             clr_cnt, adv;
  logic [CW-1:0]    ch_idx;
  logic             mcu_end, scan_end, interval_end;

  always_comb begin
    blk_sum = 0;
    blk_ok  = 1'b1;
    for (int unsigned i = 0; i < CH; i++) begin
      if (i < 32'(cfg_num_ch)) begin
        if (cfg_blk_per_ch[i] == 4'd0 || cfg_blk_per_ch[i] > 4'd4) blk_ok = 1'b0;
        blk_sum = blk_sum + 32'(cfg_blk_per_ch[i]);
      end
    end
    cfg_ok = (cfg_num_ch != '0) && (32'(cfg_num_ch) <= CH) && blk_ok &&
             (blk_sum <= MAX_BLK) && (cfg_total_mcus != '0);
  end

  // Next-state and event handling.
  always_comb begin
    state_d      = state_q;
    num_ch_d     = num_ch_q;
    blk_per_ch_d = blk_per_ch_q;
    total_d      = total_q;
    interval_d   = interval_q;
    exp_rst_d    = exp_rst_q;
    err_d        = err_q;
    dc_clr_d     = 1'b0;
    clr_cnt      = 1'b0;
    adv          = 1'b0;
    if (abort) begin
      state_d = StIdle;
      clr_cnt = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            num_ch_d     = cfg_num_ch;
            blk_per_ch_d = cfg_blk_per_ch;
            total_d      = cfg_total_mcus;
            interval_d   = cfg_rst_interval;
            if (cfg_ok) begin
              err_d     = 1'b0;
              clr_cnt   = 1'b1;
              dc_clr_d  = 1'b1;
              exp_rst_d = '0;
              state_d   = StWaitData;
            end else begin
              err_d   = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StWaitData: if (ibuff_valid) state_d = StDc;
        StDc:       if (huff_valid) state_d = StAc;
        StAc: begin
          // A symbol arriving with blk_done belongs to the finished block.
          if (blk_done) begin
            adv = 1'b1;
            if (scan_end)          state_d = StDone;
            else if (interval_end) state_d = StRstWait;
            else                   state_d = StDc;
          end
        end
        StRstWait: begin
          if (marker_seen) begin
            dc_clr_d  = 1'b1;
            exp_rst_d = exp_rst_q + 3'd1;
            if (marker_num != exp_rst_q) err_d = 1'b1;
            state_d = StDc;
          end
        end
        default: state_d = StIdle;
      endcase
      if (blk_done && state_q != StAc)         err_d = 1'b1;
      if (marker_seen && state_q != StRstWait) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      num_ch_q     <= '0;
      blk_per_ch_q <= '0;
      total_q      <= '0;
      interval_q   <= '0;
      exp_rst_q    <= '0;
      err_q        <= 1'b0;
      dc_clr_q     <= 1'b0;
      ch_out_q     <= '0;
    end else begin
      state_q      <= state_d;
      num_ch_q     <= num_ch_d;
      blk_per_ch_q <= blk_per_ch_d;
      total_q      <= total_d;
      interval_q   <= interval_d;
      exp_rst_q    <= exp_rst_d;
      err_q        <= err_d;
      dc_clr_q     <= dc_clr_d;
      ch_out_q     <= ch_idx;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle) && (state_q != StDone);
    scan_done = state_q == StDone;
    rst_wait  = state_q == StRstWait;
    freq      = state_q == StAc;
  end

  mcu_position_counter #(
    .CH    (CH),
    .MCU_W (MCU_W)
  ) u_pos (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr_cnt),
    .adv          (adv),
    .num_ch       (num_ch_q),
    .blk_per_ch   (blk_per_ch_q),
    .total_mcus   (total_q),
    .rst_interval (interval_q),
    .ch_idx       (ch_idx),
    .mcu_cnt      (mcu_cnt),
    .mcu_end      (mcu_end),
    .scan_end     (scan_end),
    .interval_end (interval_end)
  );

  assign ch          = ch_idx;
  assign ch_out      = ch_out_q;
  assign dc_pred_clr = dc_clr_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mcu_scheduler.sv
// Directed bench for mcu_scheduler: layouts, restart markers, bad configs, protocol errors, reset.
module tb_mcu_scheduler;
  import mcu_scheduler_pkg::*;

  localparam int unsigned CW = CW_DEF;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [CW-1:0]            cfg_num_ch;
  logic [CH_DEF-1:0][3:0]   cfg_blk_per_ch;
  logic [MCU_W_DEF-1:0]     cfg_total_mcus;
  logic [MCU_W_DEF-1:0]     cfg_rst_interval;
  logic                     start, abort, ibuff_valid, huff_valid, blk_done, marker_seen;
  logic [2:0]               marker_num;
  logic [CW-1:0]            ch, ch_out;
  logic                     freq, dc_pred_clr, rst_wait, busy, scan_done, err;
  logic [MCU_W_DEF-1:0]     mcu_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mcu_scheduler dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_num_ch       (cfg_num_ch),
    .cfg_blk_per_ch   (cfg_blk_per_ch),
    .cfg_total_mcus   (cfg_total_mcus),
    .cfg_rst_interval (cfg_rst_interval),
    .start            (start),
    .abort            (abort),
    .ibuff_valid      (ibuff_valid),
    .huff_valid       (huff_valid),
    .blk_done         (blk_done),
    .marker_seen      (marker_seen),
    .marker_num       (marker_num),
    .ch               (ch),
    .ch_out           (ch_out),
    .freq             (freq),
    .dc_pred_clr      (dc_pred_clr),
    .rst_wait         (rst_wait),
    .busy             (busy),
    .scan_done        (scan_done),
    .mcu_cnt          (mcu_cnt),
    .err              (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_cfg(input mcu_cfg_t c);
    cfg_num_ch       = c.num_ch;
    cfg_blk_per_ch   = c.blk_per_ch;
    cfg_total_mcus   = c.total_mcus;
    cfg_rst_interval = c.rst_interval;
  endtask

  task automatic start_scan();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Enters in DC; one DC symbol, then the block completes in AC.
  task automatic run_block(input logic [CW-1:0] exp_ch, input string tag);
    check({tag, "_ch"}, 32'(ch), 32'(exp_ch));
    check({tag, "_dc"}, 32'(freq), 32'd0);
    huff_valid = 1'b1;
    tick();
    huff_valid = 1'b0;
    check({tag, "_ac"}, 32'(freq), 32'd1);
    check({tag, "_chout"}, 32'(ch_out), 32'(exp_ch));
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
  endtask

  mcu_cfg_t c420, cgray, cbad, cmax, czero;
  logic [CW-1:0] seq420 [12];

  initial begin
    c420  = '{num_ch: 2'd3, blk_per_ch: {4'd1, 4'd1, 4'd4}, total_mcus: 16'd2, rst_interval: 16'd0};
    cgray = '{num_ch: 2'd1, blk_per_ch: {4'd0, 4'd0, 4'd1}, total_mcus: 16'd3, rst_interval: 16'd1};
    cbad  = '{num_ch: 2'd3, blk_per_ch: {4'd4, 4'd4, 4'd4}, total_mcus: 16'd2, rst_interval: 16'd0};
    cmax  = '{num_ch: 2'd3, blk_per_ch: {4'd2, 4'd4, 4'd4}, total_mcus: 16'd1, rst_interval: 16'd0};
    czero = '{num_ch: 2'd3, blk_per_ch: {4'd1, 4'd1, 4'd4}, total_mcus: 16'd0, rst_interval: 16'd0};
    seq420 = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};

    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; ibuff_valid = 1'b0; huff_valid = 1'b0;
    blk_done = 1'b0; marker_seen = 1'b0; marker_num = 3'd0;
    apply_cfg(c420);
    #12;
    check("rst_flags", 32'({busy, scan_done, rst_wait, freq, dc_pred_clr, err}), 32'd0);
    check("rst_ch", 32'({ch, ch_out}), 32'd0);
    check("rst_mcu", 32'(mcu_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_chout", 32'(ch_out), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // 4:2:0, two MCUs, no restarts.
    start_scan();
    check("t1_clr", 32'(dc_pred_clr), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    ibuff_valid = 1'b1;
    tick();
    check("t1_clr_off", 32'(dc_pred_clr), 32'd0);
    for (int i = 0; i < 12; i++) begin
      run_block(seq420[i], "t1_blk");
      if (i == 5) check("t1_mcu1", 32'(mcu_cnt), 32'd1);
    end
    check("t1_done", 32'(scan_done), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_mcu2", 32'(mcu_cnt), 32'd2);
    check("t1_ch_wrap", 32'(ch), 32'd0);

    // Grayscale, restart every MCU.
    apply_cfg(cgray);
    start_scan();
    check("t2_done_clr", 32'(scan_done), 32'd0);
    check("t2_mcu0", 32'(mcu_cnt), 32'd0);
    check("t2_clr", 32'(dc_pred_clr), 32'd1);
    tick();
    for (int m = 0; m < 2; m++) begin
      run_block(2'd0, "t2_blk");
      check("t2_rstwait", 32'(rst_wait), 32'd1);
      check("t2_mcu", 32'(mcu_cnt), 32'(m + 1));
      marker_num  = 3'(m);
      marker_seen = 1'b1;
      tick();
      marker_seen = 1'b0;
      check("t2_mk_clr", 32'(dc_pred_clr), 32'd1);
      check("t2_mk_resume", 32'({rst_wait, freq, busy}), 32'b001);
    end
    run_block(2'd0, "t2_last");
    check("t2_done", 32'(scan_done), 32'd1);
    check("t2_no_wait", 32'(rst_wait), 32'd0);
    check("t2_mcu3", 32'(mcu_cnt), 32'd3);
    check("t2_err", 32'(err), 32'd0);

    // Marker number mismatch.
    start_scan();
    tick();
    run_block(2'd0, "t3_blk");
    check("t3_rstwait", 32'(rst_wait), 32'd1);
    marker_num  = 3'd3;
    marker_seen = 1'b1;
    tick();
    marker_seen = 1'b0;
    check("t3_err", 32'(err), 32'd1);
    check("t3_resume", 32'({rst_wait, freq, busy}), 32'b001);
    check("t3_clr", 32'(dc_pred_clr), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_abort_busy", 32'(busy), 32'd0);
    check("t3_abort_err", 32'(err), 32'd1);
    check("t3_abort_mcu", 32'(mcu_cnt), 32'd0);

    // Invalid and boundary configs.
    apply_cfg(cbad);
    start_scan();
    check("t4_bad_err", 32'(err), 32'd1);
    check("t4_bad_busy", 32'(busy), 32'd0);
    check("t4_bad_clr", 32'(dc_pred_clr), 32'd0);
    apply_cfg(cmax);
    start_scan();
    check("t4_sum10_err", 32'(err), 32'd0);
    check("t4_sum10_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    apply_cfg(czero);
    start_scan();
    check("t4_zero_err", 32'(err), 32'd1);
    check("t4_zero_busy", 32'(busy), 32'd0);

    // huff_valid with blk_done in AC, then stray blk_done in DC.
    apply_cfg(c420);
    start_scan();
    tick();
    check("t5_err0", 32'(err), 32'd0);
    huff_valid = 1'b1;
    tick();
    blk_done = 1'b1;
    tick();
    huff_valid = 1'b0;
    blk_done   = 1'b0;
    check("t5_both_dc", 32'(freq), 32'd0);
    check("t5_both_err", 32'(err), 32'd0);
    blk_done = 1'b1;
    tick();
    blk_done = 1'b0;
    check("t5_stray_err", 32'(err), 32'd1);
    check("t5_stray_dc", 32'(freq), 32'd0);
    for (int i = 0; i < 3; i++) run_block(2'd0, "t5_blk");
    check("t5_ch1", 32'(ch), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset mid-MCU.
    start_scan();
    tick();
    for (int i = 0; i < 4; i++) run_block(2'd0, "t6_blk");
    huff_valid = 1'b1;
    tick();
    huff_valid = 1'b0;
    check("t6_pre_ch", 32'(ch), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_flags", 32'({busy, scan_done, rst_wait, freq, dc_pred_clr, err}), 32'd0);
    check("t6_async_ch", 32'({ch, ch_out}), 32'd0);
    check("t6_async_mcu", 32'(mcu_cnt), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    check("t6_stay_idle", 32'(busy), 32'd0);
    start_scan();
    check("t6_restart", 32'({busy, dc_pred_clr}), 32'b11);
    check("t6_restart_ch", 32'(ch), 32'd0);
    check("t6_restart_mcu", 32'(mcu_cnt), 32'd0);
    tick();
    run_block(2'd0, "t6_blk0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
